// File: rtl/msg_framer_spi_pkg.sv
// Shared definitions for the SPI message framer: FSM encoding, header
// constants and frame-layout helpers.
package msg_framer_spi_pkg;

  localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;
  localparam logic [7:0] DEF_SRC_ID    = 8'h01;

  // Frame layout: two header words, payload, one checksum word.
  localparam int unsigned HDR0_OFS   = 0;
  localparam int unsigned HDR1_OFS   = 1;
  localparam int unsigned PAY_OFS    = 2;
  localparam int unsigned CSUM_WORDS = 1;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_START = 4'd1,
    ST_LATCH = 4'd2,
    ST_HDR0  = 4'd3,
    ST_HDR1  = 4'd4,
    ST_RD    = 4'd5,
    ST_FETCH = 4'd6,
    ST_PAY   = 4'd7,
    ST_CSUM  = 4'd8
  } state_t;

  function automatic logic [15:0] csum_add(input logic [15:0] acc, input logic [15:0] word);
    return acc + word;
  endfunction

  function automatic int unsigned frame_words(input logic [7:0] len);
    return PAY_OFS + int'(len) + CSUM_WORDS;
  endfunction

  function automatic logic is_out_state(input state_t s);
    return (s == ST_HDR0) || (s == ST_HDR1) || (s == ST_PAY) || (s == ST_CSUM);
  endfunction

endpackage

// File: rtl/msg_framer_spi_csum16.sv
// 16-bit additive checksum accumulator; carries out of bit 15 are dropped.
module msg_framer_spi_csum16
  import msg_framer_spi_pkg::*;
(
  input  logic        SYS_CLK,
  input  logic        RST,
  input  logic        clr,
  input  logic        add,
  input  logic [15:0] din,
  output logic [15:0] sum
);

  always_ff @(posedge SYS_CLK) begin
    if (RST) begin
      sum <= 16'h0000;
    end else if (clr) begin
      sum <= 16'h0000;
    end else if (add) begin
      sum <= csum_add(sum, din);
    end
  end

endmodule

// File: rtl/msg_framer_spi.sv
// Drains one full SPI message from the input FIFO and emits it as a framed
// word stream: header, length, payload, checksum.
//
// Output handshake: a word transfers on a rising edge where OUT_VALID and
// OUT_READY are both high; while OUT_VALID is high and OUT_READY is low,
// OUT_VALID and OUT_DATA hold their values.
module msg_framer_spi
  import msg_framer_spi_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = DEF_SYNC_BYTE,
  parameter logic [7:0] SRC_ID    = DEF_SRC_ID
) (
  input  logic        SYS_CLK,
  input  logic        RST,
  input  logic        GOT_FULL_MSG,
  input  logic [7:0]  MSG_LEN,
  input  logic [15:0] FIFO_Q,
  output logic        MSG_START,
  output logic        RD_REQ,
  output logic [15:0] OUT_DATA,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic        BUSY,
  output logic        MSG_DONE,
  output logic [3:0]  STATE_DBG
);

  state_t      state_q, state_d;
  logic [7:0]  len_q, cnt_q;
  logic [15:0] data_q, data_d;
  logic [15:0] csum;
  logic        acc;

  logic        msg_start_d, rd_req_d, out_valid_d, busy_d, msg_done_d;
  logic [15:0] out_data_d;

  assign acc       = OUT_VALID & OUT_READY;
  assign STATE_DBG = state_q;

  msg_framer_spi_csum16 u_csum (
    .SYS_CLK (SYS_CLK),
    .RST     (RST),
    .clr     (state_q == ST_LATCH),
    .add     (state_q == ST_FETCH),
    .din     (FIFO_Q),
    .sum     (csum)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (GOT_FULL_MSG) state_d = ST_START;
      ST_START: state_d = ST_LATCH;
      ST_LATCH: state_d = (MSG_LEN == 8'd0) ? ST_IDLE : ST_HDR0;
      ST_HDR0:  if (acc) state_d = ST_HDR1;
      ST_HDR1:  if (acc) state_d = ST_RD;
      ST_RD:    state_d = ST_FETCH;
      ST_FETCH: state_d = ST_PAY;
      ST_PAY:   if (acc) state_d = (cnt_q == 8'd1) ? ST_CSUM : ST_RD;
      ST_CSUM:  if (acc) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered, so they are decoded from the state being entered.
  always_comb begin
    data_d      = (state_q == ST_FETCH) ? FIFO_Q : data_q;
    msg_start_d = (state_d == ST_START);
    rd_req_d    = (state_d == ST_RD);
    busy_d      = (state_d != ST_IDLE);
    out_valid_d = is_out_state(state_d);
    msg_done_d  = (state_q == ST_CSUM) && acc;
    out_data_d  = 16'h0000;
    case (state_d)
      ST_HDR0: out_data_d = {SYNC_BYTE, SRC_ID};
      ST_HDR1: out_data_d = {8'h00, len_q};
      ST_PAY:  out_data_d = data_d;
      ST_CSUM: out_data_d = csum;
      default: out_data_d = 16'h0000;
    endcase
  end

  always_ff @(posedge SYS_CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      len_q     <= 8'd0;
      cnt_q     <= 8'd0;
      data_q    <= 16'h0000;
      MSG_START <= 1'b0;
      RD_REQ    <= 1'b0;
      OUT_VALID <= 1'b0;
      OUT_DATA  <= 16'h0000;
      BUSY      <= 1'b0;
      MSG_DONE  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      if (state_q == ST_LATCH) begin
        len_q <= MSG_LEN;
        cnt_q <= MSG_LEN;
      end else if ((state_q == ST_PAY) && acc) begin
        cnt_q <= cnt_q - 8'd1;
      end
      MSG_START <= msg_start_d;
      RD_REQ    <= rd_req_d;
      OUT_VALID <= out_valid_d;
      OUT_DATA  <= out_data_d;
      BUSY      <= busy_d;
      MSG_DONE  <= msg_done_d;
    end
  end

endmodule

// File: tb/tb_msg_framer_spi.sv
// Bench for msg_framer_spi: directed frames, expected words queued at issue
// time and compared by an independent output monitor.
module tb_msg_framer_spi;

  logic        SYS_CLK = 1'b0;
  logic        RST;
  logic        GOT_FULL_MSG;
  logic [7:0]  MSG_LEN;
  logic [15:0] FIFO_Q;
  logic        MSG_START, RD_REQ, OUT_VALID, OUT_READY, BUSY, MSG_DONE;
  logic [15:0] OUT_DATA;
  logic [3:0]  STATE_DBG;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] exp_q[$];

  logic [15:0] fifo_mem[0:511];
  int          fifo_idx = 0;
  int          fifo_wr  = 0;

  int ready_mode   = 2;
  logic ready_manual = 1'b0;

  int rd_cnt = 0, done_cnt = 0, ms_cnt = 0, busy_cyc = 0, vld_cyc = 0, acc_cnt = 0;

  msg_framer_spi dut (
    .SYS_CLK      (SYS_CLK),
    .RST          (RST),
    .GOT_FULL_MSG (GOT_FULL_MSG),
    .MSG_LEN      (MSG_LEN),
    .FIFO_Q       (FIFO_Q),
    .MSG_START    (MSG_START),
    .RD_REQ       (RD_REQ),
    .OUT_DATA     (OUT_DATA),
    .OUT_VALID    (OUT_VALID),
    .OUT_READY    (OUT_READY),
    .BUSY         (BUSY),
    .MSG_DONE     (MSG_DONE),
    .STATE_DBG    (STATE_DBG)
  );

  // clock / reset
  always #5 SYS_CLK = ~SYS_CLK;

  // Non-show-ahead FIFO: data appears the cycle after the read strobe.
  always @(posedge SYS_CLK) begin
    if (RD_REQ) begin
      FIFO_Q   <= fifo_mem[fifo_idx];
      fifo_idx <= fifo_idx + 1;
    end
  end

  // Sink ready: 0 = always ready, 1 = toggle each cycle, 2 = manual level.
  always @(posedge SYS_CLK) begin
    #1;
    if (ready_mode == 0)      OUT_READY = 1'b1;
    else if (ready_mode == 1) OUT_READY = ~OUT_READY;
    else                      OUT_READY = ready_manual;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  logic        stall_prev = 1'b0;
  logic [15:0] data_prev  = 16'h0000;

  always @(negedge SYS_CLK) begin
    if (RST) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_valid_hold", {31'd0, OUT_VALID}, 32'd1);
        check("stall_data_hold", {16'd0, OUT_DATA}, {16'd0, data_prev});
      end
      if (OUT_VALID && OUT_READY) begin
        acc_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_word", {16'd0, OUT_DATA}, 32'hFFFF_FFFF);
        end else begin
          check("out_word", {16'd0, OUT_DATA}, {16'd0, exp_q.pop_front()});
        end
      end
      stall_prev = OUT_VALID && !OUT_READY;
      data_prev  = OUT_DATA;
      if (RD_REQ)    rd_cnt++;
      if (MSG_DONE)  done_cnt++;
      if (MSG_START) ms_cnt++;
      if (BUSY)      busy_cyc++;
      if (OUT_VALID) vld_cyc++;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge SYS_CLK);
    #1;
  endtask

  task automatic wait_for(input int which, input int bound, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge SYS_CLK);
      case (which)
        0:       seen = MSG_START;
        1:       seen = RD_REQ;
        2:       seen = MSG_DONE;
        default: seen = OUT_VALID;
      endcase
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s: event not seen within %0d cycles, expected it", name, bound);
    end
  endtask

  task automatic load_word(input logic [15:0] w);
    fifo_mem[fifo_wr] = w;
    fifo_wr++;
  endtask

  task automatic queue_frame(input int len, input int base);
    logic [15:0] sum;
    sum = 16'h0000;
    exp_q.push_back(16'hA501);
    exp_q.push_back({8'h00, 8'(len)});
    for (int i = 0; i < len; i++) begin
      exp_q.push_back(fifo_mem[base + i]);
      sum = sum + fifo_mem[base + i];
    end
    exp_q.push_back(sum);
  endtask

  task automatic start_msg(input int len);
    MSG_LEN      = 8'(len);
    GOT_FULL_MSG = 1'b1;
    wait_for(0, 10, "msg_start");
    tick();
    GOT_FULL_MSG = 1'b0;
  endtask

  int base, rd0, dn0, ms0, bz0, vl0, ac0;

  initial begin
    RST          = 1'b1;
    GOT_FULL_MSG = 1'b0;
    MSG_LEN      = 8'd0;
    repeat (3) tick();
    RST = 1'b0;
    @(negedge SYS_CLK);
    check("rst_out_valid", {31'd0, OUT_VALID}, 32'd0);
    check("rst_busy",      {31'd0, BUSY},      32'd0);
    check("rst_msg_start", {31'd0, MSG_START}, 32'd0);
    check("rst_rd_req",    {31'd0, RD_REQ},    32'd0);
    check("rst_msg_done",  {31'd0, MSG_DONE},  32'd0);
    check("rst_out_data",  {16'd0, OUT_DATA},  32'd0);
    check("rst_state",     {28'd0, STATE_DBG}, 32'd0);

    // 3-word frame, sink always ready: A501 0003 0001 0002 FFFF 0002
    ready_mode = 0;
    base = fifo_wr;
    load_word(16'h0001); load_word(16'h0002); load_word(16'hFFFF);
    queue_frame(3, base);
    rd0 = rd_cnt; dn0 = done_cnt; bz0 = busy_cyc;
    start_msg(3);
    wait_for(2, 100, "done_a");
    repeat (3) tick();
    check("a_rd_count",   rd_cnt - rd0,   3);
    check("a_done_count", done_cnt - dn0, 1);
    check("a_busy_cycles", busy_cyc - bz0, 2 + 2 + 9 + 1);
    check("a_queue_empty", exp_q.size(), 0);

    // same frame, sink ready toggling every cycle
    ready_mode = 1;
    base = fifo_wr;
    load_word(16'h0001); load_word(16'h0002); load_word(16'hFFFF);
    queue_frame(3, base);
    rd0 = rd_cnt; dn0 = done_cnt;
    start_msg(3);
    wait_for(2, 200, "done_b");
    repeat (3) tick();
    check("b_rd_count",    rd_cnt - rd0,   3);
    check("b_done_count",  done_cnt - dn0, 1);
    check("b_queue_empty", exp_q.size(), 0);

    // zero-length message: no frame, BUSY for START and LATCH only
    ready_mode = 0;
    rd0 = rd_cnt; dn0 = done_cnt; bz0 = busy_cyc; vl0 = vld_cyc;
    start_msg(0);
    repeat (8) tick();
    check("z_busy_cycles", busy_cyc - bz0, 2);
    check("z_valid_cycles", vld_cyc - vl0, 0);
    check("z_rd_count",    rd_cnt - rd0,   0);
    check("z_done_count",  done_cnt - dn0, 0);
    check("z_state_idle",  {28'd0, STATE_DBG}, 32'd0);

    // maximum length: 254 x 0101 -> checksum FEFE
    base = fifo_wr;
    for (int i = 0; i < 254; i++) load_word(16'h0101);
    queue_frame(254, base);
    rd0 = rd_cnt; dn0 = done_cnt; ac0 = acc_cnt;
    start_msg(254);
    wait_for(2, 1000, "done_max");
    repeat (3) tick();
    check("max_rd_count",   rd_cnt - rd0,   254);
    check("max_words",      acc_cnt - ac0,  257);
    check("max_done_count", done_cnt - dn0, 1);
    check("max_queue_empty", exp_q.size(), 0);

    // GOT_FULL_MSG during PAY is ignored; held high, it starts the next frame
    base = fifo_wr;
    load_word(16'h1234); load_word(16'h8765);
    queue_frame(2, base);
    base = fifo_wr;
    load_word(16'h00AA);
    queue_frame(1, base);
    rd0 = rd_cnt; dn0 = done_cnt; ms0 = ms_cnt;
    start_msg(2);
    wait_for(1, 20, "e_first_rd");
    tick(); tick();
    GOT_FULL_MSG = 1'b1;
    tick();
    GOT_FULL_MSG = 1'b0;
    check("e_pulse_ignored", ms_cnt - ms0, 1);
    MSG_LEN      = 8'd1;
    GOT_FULL_MSG = 1'b1;
    wait_for(2, 50, "e_done1");
    check("e_no_restart_before_done", ms_cnt - ms0, 1);
    wait_for(0, 10, "e_start2");
    tick();
    GOT_FULL_MSG = 1'b0;
    wait_for(2, 50, "e_done2");
    repeat (3) tick();
    check("e_start_count", ms_cnt - ms0,   2);
    check("e_rd_count",    rd_cnt - rd0,   3);
    check("e_done_count",  done_cnt - dn0, 2);
    check("e_queue_empty", exp_q.size(), 0);

    // reset while stalled in PAY: frame abandoned, no further reads
    base = fifo_wr;
    load_word(16'h5555); load_word(16'h6666); load_word(16'h7777);
    exp_q.push_back(16'hA501);
    exp_q.push_back(16'h0003);
    start_msg(3);
    wait_for(1, 20, "r_first_rd");
    ready_manual = 1'b0;
    ready_mode   = 2;
    wait_for(3, 10, "r_pay_valid");
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    @(negedge SYS_CLK);
    check("r_out_valid", {31'd0, OUT_VALID}, 32'd0);
    check("r_busy",      {31'd0, BUSY},      32'd0);
    check("r_state",     {28'd0, STATE_DBG}, 32'd0);
    rd0 = rd_cnt; dn0 = done_cnt;
    ready_mode = 0;
    repeat (10) tick();
    check("r_no_rd_after", rd_cnt - rd0,   0);
    check("r_no_done",     done_cnt - dn0, 0);
    check("r_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/msg_framer_spi.md
Name: msg_framer_spi

Overview:
- Downstream consumer of the SPI input stage.
- Waits for GOT_FULL_MSG, snapshots the message length, drains that many 16-bit words from the input FIFO, and emits a framed message on a valid/ready word stream toward the output transmitter.
- Frame layout: header word, length word, payload words, then a 16-bit additive checksum.

Parameters:
- SYNC_BYTE, 8'hA5, upper byte of header word 0
- SRC_ID, 8'h01, lower byte of header word 0 (identifies the SPI source)

Ports:
- SYS_CLK  in  1  system clock; all logic on its rising edge
- RST  in  1  synchronous, active-high reset
- GOT_FULL_MSG  in  1  upstream flag: a message is ready in the FIFO
- MSG_LEN  in  8  upstream length, valid the cycle after MSG_START; range 0..254
- FIFO_Q  in  16  FIFO read data; valid the cycle after RD_REQ (non-show-ahead)
- MSG_START  out  1  one-cycle pulse requesting a length snapshot
- RD_REQ  out  1  one-cycle FIFO read strobe
- OUT_DATA  out  16  framed word
- OUT_VALID  out  1  OUT_DATA valid
- OUT_READY  in  1  sink accepts the word when OUT_VALID & OUT_READY
- BUSY  out  1  high in every state except IDLE
- MSG_DONE  out  1  one-cycle pulse when the checksum word is accepted

Behaviour:
- Reset: state=IDLE. MSG_START, RD_REQ, OUT_VALID, BUSY and MSG_DONE are all 0. OUT_DATA=0, cnt=0, len=0, csum=0. Reset takes priority in any state, including mid-frame; FIFO words already read are discarded.
- Registered outputs, one-hot or binary FSM (implementer's choice). States:
  - IDLE: if GOT_FULL_MSG -> START.
  - START: MSG_START=1 for this cycle -> LATCH.
  - LATCH: len<=MSG_LEN, cnt<=MSG_LEN, csum<=0. If MSG_LEN==0 -> IDLE with no frame emitted and no MSG_DONE; else -> HDR0.
  - HDR0: OUT_DATA={SYNC_BYTE,SRC_ID}, OUT_VALID=1. Hold until OUT_READY, then -> HDR1.
  - HDR1: OUT_DATA={8'h00,len}. Hold until OUT_READY, then -> RD.
  - RD: RD_REQ=1 for exactly one cycle -> FETCH.
  - FETCH: data_reg<=FIFO_Q; csum<=csum+FIFO_Q (mod 2^16) -> PAY.
  - PAY: OUT_DATA=data_reg, OUT_VALID=1. On accept: cnt<=cnt-1; if cnt==1 -> CSUM, else -> RD.
  - CSUM: OUT_DATA=csum. On accept: MSG_DONE=1 for one cycle -> IDLE.
- Handshake: OUT_DATA and OUT_VALID stay stable while OUT_VALID & !OUT_READY. OUT_VALID drops in the cycle after the last accept unless the next word is immediately ready (HDR0->HDR1 may be back-to-back).
- Exactly len RD_REQ pulses per frame. Never more than one outstanding read. RD_REQ is never asserted outside RD.
- GOT_FULL_MSG is ignored outside IDLE. Upstream clears it on RD_REQ, so a re-assertion seen in IDLE means a new message.
- Minimum frame time with OUT_READY held high: 2 (START, LATCH) + 2 header + 3×len payload + 1 checksum cycles.
- Length arithmetic is 8-bit; len ≤ 254, so no wrap. The checksum wraps mod 2^16 and carries are dropped.

Decomposition:
- Shared defines file: state encodings, SPI header constants (SYNC_BYTE, SRC_ID defaults), frame word offsets.
- No sub-module required. Optional natural split: frame_csum16 (accumulator with clear/add).

Test Plan:
- Reset mid-PAY (RST high 1 cycle) -> next cycle OUT_VALID=0, BUSY=0, state IDLE; no further RD_REQ.
- GOT_FULL_MSG=1, MSG_LEN=3, FIFO words 16'h0001,16'h0002,16'hFFFF, OUT_READY=1 -> stream A501, 0003, 0001, 0002, FFFF, 0002; 3 RD_REQ pulses; one MSG_DONE.
- Same as above with OUT_READY toggling 1/0 every cycle -> identical word sequence; OUT_DATA stable while stalled; RD_REQ count still 3.
- MSG_LEN=0 after MSG_START -> no OUT_VALID, no RD_REQ, no MSG_DONE; BUSY high for exactly 2 cycles.
- MSG_LEN=254, all words 16'h0101 -> 257 words total; checksum = (254×257) mod 65536 = 16'hFEFE; 254 RD_REQ pulses.
- GOT_FULL_MSG pulsed again during PAY -> ignored; a second frame starts only after MSG_DONE, if the flag is high in IDLE.
